// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the instruction sequencer.
//   state_t  - sequencer FSM states (STEP_WAIT exists only when the
//              SEQ_SINGLE_STEP_EN macro is defined)
//   CLS_*    - instruction class codes, instr[15:13]
//   SYS_*    - system-class sub-ops carried in the fs field
//   BS_*     - brancher select encodings
//   MD_*     - mux D select encodings
//   ctrl_t   - datapath control word registered at DECODE
package seq_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;

  localparam logic [2:0] CLS_ALU_REG  = 3'b000;
  localparam logic [2:0] CLS_ALU_IMMZ = 3'b001;
  localparam logic [2:0] CLS_ALU_IMMS = 3'b010;
  localparam logic [2:0] CLS_LD       = 3'b011;
  localparam logic [2:0] CLS_ST       = 3'b100;
  localparam logic [2:0] CLS_IN       = 3'b101;
  localparam logic [2:0] CLS_BR       = 3'b110;
  localparam logic [2:0] CLS_SYS      = 3'b111;

  localparam logic [3:0] SYS_NOP = 4'b0000;
  localparam logic [3:0] SYS_HLT = 4'b0001;
  localparam logic [3:0] SYS_LPC = 4'b0010;

  localparam logic [1:0] BS_PC   = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JMP  = 2'b10;
  localparam logic [1:0] BS_BRA  = 2'b11;

  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_IN  = 2'b10;

  localparam logic [3:0] FS_PASS_A = 4'b0000;

  typedef struct packed {
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       ma;
    logic       mb;
    logic       cs;
    logic [1:0] md;
    logic [3:0] fs;
    logic [1:0] bs;
    logic       ps;
    logic [5:0] imm;
    logic       we;   // store (drives dmem_we)
    logic       wr;   // register write in EXEC
  } ctrl_t;

endpackage

// File: rtl/seq_decoder.sv
// seq_decoder: purely combinational decode of the instruction register.
//   ir      in   16  latched instruction word
//   ctrl    out  ctrl_t datapath control word for this instruction
//   mem_op  out  1   instruction needs the MEM state (LD or ST)
//   halt    out  1   HLT instruction
//   legal   out  1   0 for an undefined system sub-op
module seq_decoder
  import seq_pkg::*;
(
  input  logic [15:0] ir,
  output ctrl_t       ctrl,
  output logic        mem_op,
  output logic        halt,
  output logic        legal
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    ctrl   = '0;
    mem_op = 1'b0;
    halt   = 1'b0;
    legal  = 1'b1;
    ctrl.da = ir[8:6];
    ctrl.aa = ir[5:3];
    ctrl.ba = ir[2:0];
    ctrl.fs = ir[12:9];
    case (ir[15:13])
      CLS_ALU_REG: ctrl.wr = 1'b1;
      CLS_ALU_IMMZ: begin
        ctrl.mb  = 1'b1;
        ctrl.imm = ir[5:0];
        ctrl.wr  = 1'b1;
      end
      CLS_ALU_IMMS: begin
        ctrl.mb  = 1'b1;
        ctrl.cs  = 1'b1;
        ctrl.imm = ir[5:0];
        ctrl.wr  = 1'b1;
      end
      CLS_LD: begin
        ctrl.md = MD_MEM;
        mem_op  = 1'b1;
      end
      CLS_ST: begin
        ctrl.we = 1'b1;
        mem_op  = 1'b1;
      end
      CLS_IN: begin
        ctrl.md = MD_IN;
        ctrl.wr = 1'b1;
      end
      CLS_BR: begin
        // Branch offset is split around the SA field.
        ctrl.imm = {ir[8:6], ir[2:0]};
        case (ir[10:9])
          2'b00:   ctrl.bs = BS_COND;
          2'b01: begin
            ctrl.bs = BS_COND;
            ctrl.ps = 1'b1;
          end
          2'b10:   ctrl.bs = BS_JMP;
          default: ctrl.bs = BS_BRA;
        endcase
      end
      default: begin
        case (ir[12:9])
          SYS_NOP: ;
          SYS_HLT: halt = 1'b1;
          SYS_LPC: begin
            ctrl.ma = 1'b1;
            ctrl.fs = FS_PASS_A;
            ctrl.wr = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle sequencer for the 8-bit datapath.
// Fetches over imem req/ack, owns pc / pc_prev, registers the decoded
// control word at DECODE and steps FETCH/DECODE/EXEC/MEM/WB/HALT.
// Optional feature: SEQ_SINGLE_STEP_EN adds the step port and a STEP_WAIT
// state that gates each new fetch on step=1.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req/imem_ack/instr    instruction fetch handshake, address = pc
//   dmem_req/dmem_we/dmem_ack  data transfer handshake (we=1 store)
//   pc_next                    next PC from mux C, loaded on pc_load
//   pc, pc_prev                current PC, PC of the instruction in flight
//   da, aa, ba, ma, mb, cs, md, fs, bs, ps, imm   datapath control word
//   rw                         register-file write enable
//   halted, illegal            core stopped / stopped on illegal opcode
//   step                       single-step advance (macro builds only)
module seq_control_unit
  import seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] instr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic [7:0]  pc_next,
  output logic [7:0]  pc,
  output logic [7:0]  pc_prev,
  output logic [2:0]  da,
  output logic [2:0]  aa,
  output logic [2:0]  ba,
  output logic        ma,
  output logic        mb,
  output logic        cs,
  output logic [1:0]  md,
  output logic [3:0]  fs,
  output logic [1:0]  bs,
  output logic        ps,
  output logic        rw,
  output logic [5:0]  imm,
  output logic        halted,
  output logic        illegal
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic        step
`endif
);

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t S_DONE = S_STEP_WAIT;
`else
  localparam state_t S_DONE = S_FETCH;
`endif

  state_t      state, state_nxt;
  logic [15:0] ir;
  ctrl_t       ctrl_q, dec_ctrl;
  logic        dec_mem, dec_halt, dec_legal;
  logic        pc_load;

  seq_decoder u_dec (
    .ir    (ir),
    .ctrl  (dec_ctrl),
    .mem_op(dec_mem),
    .halt  (dec_halt),
    .legal (dec_legal)
  );

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    rw        = 1'b0;
    pc_load   = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (dec_halt || !dec_legal) state_nxt = S_HALT;
        else if (dec_mem)           state_nxt = S_MEM;
        else                        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        rw        = ctrl_q.wr;
        pc_load   = 1'b1;
        state_nxt = S_DONE;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (ctrl_q.we) begin
            pc_load   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rw        = 1'b1;
        pc_load   = 1'b1;
        state_nxt = S_DONE;
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_STEP_WAIT: if (step) state_nxt = S_FETCH;
`endif
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state   <= S_RESET;
      pc      <= RESET_PC;
      pc_prev <= '0;
      // NOTE: ir is reset too, so the decoder never sees an unknown word.
      ir      <= '0;
      ctrl_q  <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) begin
        ir      <= instr;
        pc_prev <= pc;
      end
      if (state == S_DECODE) begin
        ctrl_q  <= dec_ctrl;
        illegal <= !dec_legal;
      end
      if (pc_load) pc <= pc_next;
    end
  end

  assign halted  = (state == S_HALT);
  assign dmem_we = ctrl_q.we;
  assign da      = ctrl_q.da;
  assign aa      = ctrl_q.aa;
  assign ba      = ctrl_q.ba;
  assign ma      = ctrl_q.ma;
  assign mb      = ctrl_q.mb;
  assign cs      = ctrl_q.cs;
  assign md      = ctrl_q.md;
  assign fs      = ctrl_q.fs;
  assign bs      = ctrl_q.bs;
  assign ps      = ctrl_q.ps;
  assign imm     = ctrl_q.imm;

endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: self-checking bench for seq_control_unit (default
// build, RESET_PC = 8'h10). A table of hand-derived vectors, randomized
// instructions checked against a behavioural model, and hand-written
// sequences for halt, illegal and reset-during-MEM.
module tb_seq_control_unit;

  localparam logic [7:0] RST_PC = 8'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [15:0] instr = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [7:0]  pc_next = '0;
  logic [7:0]  pc, pc_prev;
  logic [2:0]  da, aa, ba;
  logic        ma, mb, cs, ps, rw, halted, illegal;
  logic [1:0]  md, bs;
  logic [3:0]  fs;
  logic [5:0]  imm;

  seq_control_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_next(pc_next), .pc(pc), .pc_prev(pc_prev),
    .da(da), .aa(aa), .ba(ba), .ma(ma), .mb(mb), .cs(cs),
    .md(md), .fs(fs), .bs(bs), .ps(ps), .rw(rw), .imm(imm),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Observable control word: {da,aa,ba,ma,mb,cs,md,fs,bs,ps,imm,dmem_we}
  typedef struct packed {
    logic [2:0] da, aa, ba;
    logic       ma, mb, cs;
    logic [1:0] md;
    logic [3:0] fs;
    logic [1:0] bs;
    logic       ps;
    logic [5:0] imm;
    logic       we;
  } ctl_t;

  typedef struct {
    logic [15:0] w;
    int          idly, ddly;
    logic        fnxt;
    logic [7:0]  nxt;
    ctl_t        ctl;
    int          lat, rws, rw_at, dq;
  } vec_t;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_pc;
  vec_t       tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ctl_t obs_ctl();
    return {da, aa, ba, ma, mb, cs, md, fs, bs, ps, imm, dmem_we};
  endfunction

  function automatic ctl_t mk(input logic [2:0] d, a, b, input logic m_a, m_b, c_s,
                              input logic [1:0] m_d, input logic [3:0] f,
                              input logic [1:0] b_s, input logic p_s,
                              input logic [5:0] im, input logic w_e);
    return {d, a, b, m_a, m_b, c_s, m_d, f, b_s, p_s, im, w_e};
  endfunction

  function automatic void add(input logic [15:0] w, input int idly, input int ddly,
                              input logic fnxt, input logic [7:0] nxt, input ctl_t c,
                              input int lat, input int rws, input int rw_at, input int dq);
    vec_t v;
    v.w = w; v.idly = idly; v.ddly = ddly; v.fnxt = fnxt; v.nxt = nxt;
    v.ctl = c; v.lat = lat; v.rws = rws; v.rw_at = rw_at; v.dq = dq;
    tbl.push_back(v);
  endfunction

  // ---------------- behavioural reference model ----------------
  function automatic ctl_t model_ctl(input logic [15:0] w);
    ctl_t       c = '0;
    logic [3:0] f = w[12:9];
    c.da = w[8:6]; c.aa = w[5:3]; c.ba = w[2:0]; c.fs = f;
    case (w[15:13])
      3'd1: begin c.mb = 1'b1; c.imm = w[5:0]; end
      3'd2: begin c.mb = 1'b1; c.cs = 1'b1; c.imm = w[5:0]; end
      3'd3: c.md = 2'b01;
      3'd4: c.we = 1'b1;
      3'd5: c.md = 2'b10;
      3'd6: begin
        c.imm = {w[8:6], w[2:0]};
        c.bs  = (f[1:0] == 2'b00) ? 2'b01 : f[1:0];
        c.ps  = (f[1:0] == 2'b01);
      end
      3'd7: if (f == 4'd2) begin c.ma = 1'b1; c.fs = 4'd0; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit model_writes(input logic [15:0] w);
    int cls = int'(w[15:13]);
    return (cls <= 3) || (cls == 5) || (cls == 7 && w[12:9] == 4'd2);
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_fetch(input string name);
    for (int i = 0; i < 8 && !imem_req; i++) @(negedge clk);
    check({name, " fetch_ready"}, 32'(imem_req), 32'd1);
  endtask

  // Called at a negedge in FETCH. Drives one instruction to completion
  // (next FETCH or HALT), injecting ignored ack noise while req is low.
  task automatic run_instr(input logic [15:0] w, input int idly, input int ddly,
                           input logic [7:0] n, output ctl_t c, output int lat,
                           output int rws, output int rw_at, output int dq, output logic hh);
    int k;
    c = '0; lat = -1; rws = 0; rw_at = -1; dq = 0; hh = 1'b0;
    instr = w; pc_next = n; dmem_ack = 1'b0;
    for (int i = 0; i < idly; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    k = idly + 1;
    while (k < idly + 40) begin
      if (k == idly + 2) c = obs_ctl();
      if (imem_req) begin lat = k; break; end
      if (halted) begin hh = 1'b1; lat = k; break; end
      if (rw) begin rws++; rw_at = k; end
      if (dmem_req) begin
        dq++;
        dmem_ack = (dq > ddly);
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
      end
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic exec_and_check(input string name, input logic [15:0] w, input int idly,
                                input int ddly, input logic [7:0] n, input ctl_t ec,
                                input int elat, input int erws, input int erw_at, input int edq);
    ctl_t       c;
    int         lat, rws, rw_at, dq;
    logic       hh;
    logic [7:0] start_pc = exp_pc;
    wait_fetch(name);
    run_instr(w, idly, ddly, n, c, lat, rws, rw_at, dq, hh);
    check({name, " ctl"}, 32'(c), 32'(ec));
    check({name, " latency"}, lat, elat);
    check({name, " rw_count"}, rws, erws);
    check({name, " rw_cycle"}, rw_at, erw_at);
    check({name, " dmem_req_cycles"}, dq, edq);
    check({name, " halted"}, 32'(hh), 32'd0);
    check({name, " pc"}, 32'(pc), 32'(n));
    check({name, " pc_prev"}, 32'(pc_prev), 32'(start_pc));
    exp_pc = n;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({name, " imem_req"}, 32'(imem_req), 32'd0);
    check({name, " dmem_req"}, 32'(dmem_req), 32'd0);
    check({name, " rw"}, 32'(rw), 32'd0);
    check({name, " halted"}, 32'(halted), 32'd0);
    check({name, " illegal"}, 32'(illegal), 32'd0);
    check({name, " pc"}, 32'(pc), 32'(RST_PC));
    check({name, " pc_prev"}, 32'(pc_prev), 32'd0);
    check({name, " ctl"}, 32'(obs_ctl()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check({name, " req_rise"}, 32'(imem_req), 32'd1);
    exp_pc = RST_PC;
  endtask

  initial begin
    ctl_t       c;
    int         lat, rws, rw_at, dq;
    logic       hh, req_seen;
    logic [7:0] n, hold_pc;

    // {instr, idly, ddly, force_next, next, ctl, latency, rw count, rw cycle, dmem_req cycles}
    add({3'b010, 4'b0010, 3'b011, 6'b100101}, 0, 0, 1'b0, 8'h00,
        mk(3'd3, 3'd4, 3'd5, 1'b0, 1'b1, 1'b1, 2'd0, 4'd2, 2'd0, 1'b0, 6'b100101, 1'b0), 3, 1, 2, 0);
    add({3'b000, 4'b0101, 3'b001, 3'b010, 3'b011}, 0, 0, 1'b0, 8'h00,
        mk(3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 4'd5, 2'd0, 1'b0, 6'd0, 1'b0), 3, 1, 2, 0);
    add({3'b001, 4'b1000, 3'b111, 3'b000, 3'b001}, 1, 0, 1'b0, 8'h00,
        mk(3'd7, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd8, 2'd0, 1'b0, 6'b000001, 1'b0), 4, 1, 3, 0);
    add({3'b011, 4'b0000, 3'b100, 3'b001, 3'b000}, 0, 2, 1'b0, 8'h00,
        mk(3'd4, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 2'd0, 1'b0, 6'd0, 1'b0), 6, 1, 5, 3);
    add({3'b011, 4'b0000, 3'b010, 3'b110, 3'b000}, 0, 0, 1'b0, 8'h00,
        mk(3'd2, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 2'd0, 1'b0, 6'd0, 1'b0), 4, 1, 3, 1);
    add({3'b100, 4'b0000, 3'b000, 3'b010, 3'b011}, 0, 0, 1'b0, 8'h00,
        mk(3'd0, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 6'd0, 1'b1), 3, 0, -1, 1);
    add({3'b100, 4'b0000, 3'b000, 3'b111, 3'b001}, 0, 1, 1'b0, 8'h00,
        mk(3'd0, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 6'd0, 1'b1), 4, 0, -1, 2);
    add({3'b101, 4'b0000, 3'b110, 3'b000, 3'b000}, 0, 0, 1'b1, 8'hFF,
        mk(3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 2'd0, 1'b0, 6'd0, 1'b0), 3, 1, 2, 0);
    add({3'b110, 4'b0001, 3'b010, 3'b011, 3'b101}, 0, 0, 1'b1, 8'h00,
        mk(3'd2, 3'd3, 3'd5, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 2'd1, 1'b1, 6'b010101, 1'b0), 3, 0, -1, 0);
    add({3'b110, 4'b0000, 3'b001, 3'b000, 3'b111}, 0, 0, 1'b0, 8'h00,
        mk(3'd1, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd1, 1'b0, 6'b001111, 1'b0), 3, 0, -1, 0);
    add({3'b110, 4'b0010, 3'b000, 3'b101, 3'b000}, 0, 0, 1'b0, 8'h00,
        mk(3'd0, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 2'd2, 1'b0, 6'd0, 1'b0), 3, 0, -1, 0);
    add({3'b110, 4'b0011, 3'b111, 3'b000, 3'b110}, 0, 0, 1'b0, 8'h00,
        mk(3'd7, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3, 2'd3, 1'b0, 6'b111110, 1'b0), 3, 0, -1, 0);
    add({3'b111, 4'b0000, 9'd0}, 0, 0, 1'b0, 8'h00,
        mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 6'd0, 1'b0), 3, 0, -1, 0);
    add({3'b111, 4'b0010, 3'b101, 6'd0}, 0, 0, 1'b0, 8'h00,
        mk(3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 6'd0, 1'b0), 3, 1, 2, 0);
    add({3'b111, 4'b0010, 3'b011, 6'd0}, 2, 0, 1'b0, 8'h00,
        mk(3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 6'd0, 1'b0), 5, 1, 4, 0);

    do_reset("reset0");

    foreach (tbl[i]) begin
      n = tbl[i].fnxt ? tbl[i].nxt : exp_pc + 8'd1;
      exec_and_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].idly, tbl[i].ddly, n,
                     tbl[i].ctl, tbl[i].lat, tbl[i].rws, tbl[i].rw_at, tbl[i].dq);
    end

    // Randomized instructions (HLT and illegal excluded) against the model.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] w = 16'($urandom);
      int idly = $urandom_range(0, 2);
      int ddly = $urandom_range(0, 3);
      int cls, elat, erw_at, edq;
      bit wr;
      if (w[15:13] == 3'b111) w[12:9] = ($urandom_range(0, 1) == 1) ? 4'd2 : 4'd0;
      cls    = int'(w[15:13]);
      wr     = model_writes(w);
      elat   = 3 + idly + ((cls == 3) ? 1 : 0) + ((cls == 3 || cls == 4) ? ddly : 0);
      erw_at = !wr ? -1 : (cls == 3) ? idly + 3 + ddly : idly + 2;
      edq    = (cls == 3 || cls == 4) ? ddly + 1 : 0;
      exec_and_check($sformatf("rand%0d", r), w, idly, ddly, 8'($urandom), model_ctl(w),
                     elat, wr ? 1 : 0, erw_at, edq);
    end

    // Illegal system sub-op: halts with illegal set, pc stays on the word.
    wait_fetch("illegal");
    hold_pc = exp_pc;
    run_instr({3'b111, 4'b1111, 9'd0}, 0, 0, exp_pc + 8'd1, c, lat, rws, rw_at, dq, hh);
    check("illegal halted", 32'(halted), 32'd1);
    check("illegal flag", 32'(illegal), 32'd1);
    check("illegal latency", lat, 2);
    req_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      req_seen |= imem_req | dmem_req | rw;
    end
    imem_ack = 1'b0;
    check("illegal stays_idle", 32'(req_seen), 32'd0);
    check("illegal pc_hold", 32'(pc), 32'(hold_pc));
    do_reset("reset_after_illegal");

    // HLT: halted without illegal.
    wait_fetch("hlt");
    hold_pc = exp_pc;
    run_instr({3'b111, 4'b0001, 9'd0}, 1, 0, exp_pc + 8'd1, c, lat, rws, rw_at, dq, hh);
    check("hlt halted", 32'(halted), 32'd1);
    check("hlt illegal", 32'(illegal), 32'd0);
    check("hlt rw_count", rws, 0);
    check("hlt pc_hold", 32'(pc), 32'(hold_pc));
    do_reset("reset_after_hlt");

    // Reset during MEM of a store abandons the transfer.
    wait_fetch("rst_mem");
    instr = {3'b100, 4'b0000, 3'b000, 3'b001, 3'b010};
    pc_next = 8'h77;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check("rst_mem in_mem", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mem dmem_req_drop", 32'(dmem_req), 32'd0);
    check("rst_mem rw", 32'(rw), 32'd0);
    check("rst_mem pc", 32'(pc), 32'(RST_PC));
    reset = 1'b0;
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("rst_mem restart_req", 32'(imem_req), 32'd1);
    check("rst_mem restart_dmem", 32'(dmem_req), 32'd0);
    check("rst_mem restart_pc", 32'(pc), 32'(RST_PC));
    exp_pc = RST_PC;
    exec_and_check("after_rst_mem", {3'b000, 4'b0011, 3'b010, 3'b001, 3'b100}, 0, 0,
                   RST_PC + 8'd1,
                   mk(3'd2, 3'd1, 3'd4, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3, 2'd0, 1'b0, 6'd0, 1'b0),
                   3, 1, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
